// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU command driver, plus the
// reference ALU function used by the optional self-check path.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [2:0]               sel;
    } cmd_t;

    // Returns {y, carry, zero}; SUB carry flags a borrow (a < b).
    function automatic logic [DEFAULT_WIDTH+1:0] alu_ref(
        input logic [DEFAULT_WIDTH-1:0] a,
        input logic [DEFAULT_WIDTH-1:0] b,
        input logic [2:0]               sel
    );
        logic [DEFAULT_WIDTH:0]   sum;
        logic [DEFAULT_WIDTH-1:0] y;
        logic                     carry;
        sum   = {(DEFAULT_WIDTH+1){1'b0}};
        y     = {DEFAULT_WIDTH{1'b0}};
        carry = 1'b0;
        case (sel)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[DEFAULT_WIDTH-1:0];
                carry = sum[DEFAULT_WIDTH];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            default: y = {DEFAULT_WIDTH{1'b0}};
        endcase
        return {y, carry, (y == {DEFAULT_WIDTH{1'b0}})};
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous show-ahead command FIFO; push when full and pop when empty are ignored.
module alu_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; contents are only observed once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives queued ALU commands one at a time, waits SETTLE cycles, returns results over valid/ready.
// Optional build macro ALU_SELF_CHECK_EN adds a reference-model compare (rsp_mismatch, err_count).
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [2:0]       rsp_sel,
    output logic             busy
`ifdef ALU_SELF_CHECK_EN
    ,
    output logic             rsp_mismatch,
    output logic [7:0]       err_count
`endif
);
    localparam int CMD_W = 2 * WIDTH + 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic             load_s;
    logic             capture_s;
    logic             consume_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [AW:0]      fifo_count_s;
    logic [CMD_W-1:0] head_s;

    // Acceptance depends only on occupancy, so a pop in the same cycle cannot make room.
    assign cmd_ready = !rst && !fifo_full_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign busy      = (fifo_count_s != {(AW+1){1'b0}}) || (state_r != ST_IDLE);

    alu_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (load_s),
        .wdata ({cmd_a, cmd_b, cmd_sel}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Next-state and control strobes; RESP reloads directly so back-to-back commands skip IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        capture_s    = 1'b0;
        consume_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    load_s       = 1'b1;
                    cnt_next_s   = CW'(SETTLE - 1);
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s   = cnt_r - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    consume_s = 1'b1;
                    if (!fifo_empty_s) begin
                        load_s       = 1'b1;
                        cnt_next_s   = CW'(SETTLE - 1);
                        state_next_s = ST_SETTLE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, ALU drive registers and the response holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            alu_a     <= {WIDTH{1'b0}};
            alu_b     <= {WIDTH{1'b0}};
            alu_sel   <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_y     <= {WIDTH{1'b0}};
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_sel   <= 3'b000;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (load_s) begin
                alu_a   <= head_s[CMD_W-1 -: WIDTH];
                alu_b   <= head_s[3 +: WIDTH];
                alu_sel <= head_s[2:0];
            end
            if (capture_s) begin
                rsp_valid <= 1'b1;
                rsp_y     <= alu_y;
                rsp_carry <= alu_carry;
                rsp_zero  <= alu_zero;
                rsp_sel   <= alu_sel;
            end else if (consume_s) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SELF_CHECK_EN
    logic [WIDTH+1:0] ref_s;
    logic             mismatch_s;

    assign ref_s      = alu_ref(alu_a, alu_b, alu_sel);
    assign mismatch_s = (ref_s != {alu_y, alu_carry, alu_zero});

    // Compare against the reference at capture time; error counter saturates at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_mismatch <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            if (capture_s) begin
                rsp_mismatch <= mismatch_s;
                if (mismatch_s && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (consume_s) begin
                rsp_mismatch <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: queue-based response model plus directed literal checks.
// Build with ALU_SELF_CHECK_EN defined to also exercise the mismatch/err_count path.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic force_y;
    logic check_en;

    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
    logic [2:0] cmd_sel, alu_sel, rsp_sel;
    logic       alu_carry, alu_zero, rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
    logic [5:0] alu_res;

    logic       cmd_valid3, cmd_ready3;
    logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_y3, rsp_y3;
    logic [2:0] cmd_sel3, alu_sel3, rsp_sel3;
    logic       alu_carry3, alu_zero3, rsp_valid3, rsp_ready3, rsp_carry3, rsp_zero3, busy3;
    logic [5:0] alu_res3;
`ifdef ALU_SELF_CHECK_EN
    logic       rsp_mismatch, rsp_mismatch3;
    logic [7:0] err_count, err_count3;
`endif

    // Behavioural ALU: returns {y, carry, zero} using integer arithmetic.
    function automatic logic [5:0] model_alu(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] sel);
        int  ia, ib, y;
        bit  c;
        ia = int'(a); ib = int'(b); c = 1'b0; y = 0;
        case (sel)
            3'd0: begin y = ia + ib; c = (y > 15); y = y % 16; end
            3'd1: begin c = (ia < ib); y = (ia - ib + 16) % 16; end
            3'd2: y = int'(a & b);
            3'd3: y = int'(a | b);
            3'd4: y = 15 - ia;
            default: y = 0;
        endcase
        return {4'(y), c, (y == 0)};
    endfunction

    assign alu_res    = model_alu(alu_a, alu_b, alu_sel);
    assign alu_y      = force_y ? 4'd9 : alu_res[5:2];
    assign alu_carry  = alu_res[1];
    assign alu_zero   = alu_res[0];
    assign alu_res3   = model_alu(alu_a3, alu_b3, alu_sel3);
    assign alu_y3     = alu_res3[5:2];
    assign alu_carry3 = alu_res3[1];
    assign alu_zero3  = alu_res3[0];

    alu_cmd_driver #(.WIDTH(4), .DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sel(rsp_sel), .busy(busy)
`ifdef ALU_SELF_CHECK_EN
        , .rsp_mismatch(rsp_mismatch), .err_count(err_count)
`endif
    );

    alu_cmd_driver #(.WIDTH(4), .DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_sel(cmd_sel3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_y(alu_y3), .alu_carry(alu_carry3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_y(rsp_y3),
        .rsp_carry(rsp_carry3), .rsp_zero(rsp_zero3), .rsp_sel(rsp_sel3), .busy(busy3)
`ifdef ALU_SELF_CHECK_EN
        , .rsp_mismatch(rsp_mismatch3), .err_count(err_count3)
`endif
    );

    typedef struct {
        logic [2:0] sel;
        logic [3:0] y;
        logic       c;
        logic       z;
        logic       mm;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t log_q[$];
    int   cons_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   prev_stall = 1'b0;
    logic [9:0] prev_rsp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: sampled on the falling edge, decisions apply to the next rising edge.
    always @(negedge clk) begin
        rsp_t       e;
        logic [5:0] m;
        if (check_en) begin
            chk("busy", busy, 32'(exp_q.size() != 0));
            chk("rsp_orphan", 32'(rsp_valid && (exp_q.size() == 0)), 32'd0);
            if (prev_stall) begin
                chk("rsp_hold_valid", rsp_valid, 32'd1);
                chk("rsp_hold_data", {rsp_sel, rsp_y, rsp_carry, rsp_zero}, prev_rsp);
            end
            if (rst) begin
                chk("cmd_ready_in_rst", cmd_ready, 32'd0);
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (rsp_valid && rsp_ready && (exp_q.size() != 0)) begin
                    e = exp_q.pop_front();
                    chk("rsp_sel", rsp_sel, e.sel);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_carry", rsp_carry, e.c);
                    chk("rsp_zero", rsp_zero, e.z);
`ifdef ALU_SELF_CHECK_EN
                    chk("rsp_mismatch", rsp_mismatch, e.mm);
`endif
                    e.y = rsp_y; e.c = rsp_carry; e.z = rsp_zero; e.sel = rsp_sel;
                    log_q.push_back(e);
                    cons_cyc.push_back(cyc);
                end
                if (cmd_valid && cmd_ready) begin
                    m     = model_alu(cmd_a, cmd_b, cmd_sel);
                    e.sel = cmd_sel;
                    e.y   = force_y ? 4'd9 : m[5:2];
                    e.c   = m[1];
                    e.z   = m[0];
                    e.mm  = force_y;
                    exp_q.push_back(e);
                end
                prev_stall = rsp_valid && !rsp_ready;
                prev_rsp   = {rsp_sel, rsp_y, rsp_carry, rsp_zero};
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bit ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send3(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bit ok = 1'b0;
        cmd_a3 = a; cmd_b3 = b; cmd_sel3 = s; cmd_valid3 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready3) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send3_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && (exp_q.size() == 0)) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_log(input int idx, input logic [2:0] s, input logic [3:0] y,
                           input logic c, input logic z);
        if (idx >= log_q.size()) begin
            chk("log_missing", 32'(idx), 32'(log_q.size()));
        end else begin
            chk("lit_sel", log_q[idx].sel, s);
            chk("lit_y", log_q[idx].y, y);
            chk("lit_carry", log_q[idx].c, c);
            chk("lit_zero", log_q[idx].z, z);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ey [6];
        logic [2:0] es [6];
        logic       ec [6];
        logic       ez [6];
        int         first;
        bit         seen;
        rst = 1'b1; force_y = 1'b0; check_en = 1'b0;
        cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_sel = 3'd0; rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; cmd_a3 = 4'd0; cmd_b3 = 4'd0; cmd_sel3 = 3'd0; rsp_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        check_en = 1'b1;
        tick();
        chk("reset_rsp_valid", rsp_valid, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_alu", {alu_a, alu_b, alu_sel}, 32'd0);
        chk("reset_rsp", {rsp_y, rsp_sel, rsp_carry, rsp_zero}, 32'd0);
        chk("reset_cmd_ready", cmd_ready, 32'd0);
        rst = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 32'd1);

        // 1: every op on A=3,B=5, back-to-back, consumer always ready
        rsp_ready = 1'b1;
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        ey = '{4'd8, 4'd14, 4'd1, 4'd7, 4'd12, 4'd0};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) send(4'd3, 4'd5, es[i]);
        wait_idle();
        chk("t1_count", log_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk_log(i, es[i], ey[i], ec[i], ez[i]);
        for (int i = 1; i < 6 && i < cons_cyc.size(); i++)
            chk("t1_throughput", cons_cyc[i] - cons_cyc[i-1], 32'd2);

        // 2: carry/zero corner cases
        send(4'd15, 4'd1, OP_ADD);
        send(4'd5, 4'd5, OP_SUB);
        wait_idle();
        chk_log(6, OP_ADD, 4'd0, 1'b1, 1'b1);
        chk_log(7, OP_SUB, 4'd0, 1'b0, 1'b1);

        // 3: capacity with stalled consumer
        rsp_ready = 1'b0;
        send(4'd1, 4'd2, OP_ADD);
        send(4'd9, 4'd4, OP_SUB);
        send(4'd12, 4'd10, OP_AND);
        send(4'd5, 4'd8, OP_OR);
        send(4'd6, 4'd0, OP_NOT);
        cmd_a = 4'd7; cmd_b = 4'd7; cmd_sel = OP_ADD; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_sixth_stalls", cmd_ready, 32'd0);
        end
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_before_pop", cmd_ready, 32'd0);
        @(negedge clk);
        chk("t3_ready_after_pop", cmd_ready, 32'd1);
        @(posedge clk); #1;
        wait_idle();
        chk("t3_count", log_q.size(), 32'd13);
        chk_log(8, OP_ADD, 4'd3, 1'b0, 1'b0);
        chk_log(9, OP_SUB, 4'd5, 1'b0, 1'b0);
        chk_log(10, OP_AND, 4'd8, 1'b0, 1'b0);
        chk_log(11, OP_OR, 4'd13, 1'b0, 1'b0);
        chk_log(12, OP_NOT, 4'd9, 1'b0, 1'b0);

        // 4: SETTLE=3 latency
        send3(4'd6, 4'd3, OP_SUB);
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rsp_valid3 && first < 0) first = k;
        end
        chk("t4_latency", 32'(first), 32'd4);
        chk("t4_rsp", {rsp_sel3, rsp_y3, rsp_carry3, rsp_zero3}, {3'd1, 4'd3, 1'b0, 1'b0});
        rsp_ready3 = 1'b1;
        tick();
        rsp_ready3 = 1'b0;
        chk("t4_consumed", rsp_valid3, 32'd0);
        chk("t4_idle", busy3, 32'd0);

        // 5: reset during SETTLE with two commands queued
        send3(4'd1, 4'd1, OP_ADD);
        send3(4'd2, 4'd2, OP_ADD);
        send3(4'd3, 4'd3, OP_ADD);
        chk("t5_pre_valid", rsp_valid3, 32'd0);
        chk("t5_pre_busy", busy3, 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rsp_valid", rsp_valid3, 32'd0);
        chk("t5_busy", busy3, 32'd0);
        chk("t5_alu", {alu_a3, alu_b3, alu_sel3}, 32'd0);
        chk("t5_rsp", {rsp_y3, rsp_sel3, rsp_carry3, rsp_zero3}, 32'd0);
        chk("t5_cmd_ready", cmd_ready3, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid3 || busy3) seen = 1'b1;
        end
        chk("t5_no_response", seen, 32'd0);

`ifdef ALU_SELF_CHECK_EN
        // 6: corrupted ALU result is flagged and counted
        chk("t6_err_clear", err_count, 32'd0);
        force_y = 1'b1;
        rsp_ready = 1'b0;
        send(4'd3, 4'd5, OP_ADD);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk("t6_rsp_seen", seen, 32'd1);
        chk("t6_mismatch", rsp_mismatch, 32'd1);
        chk("t6_err_count", err_count, 32'd1);
        chk("t6_rsp_y", rsp_y, 32'd9);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();
        force_y = 1'b0;
        send(4'd3, 4'd5, OP_ADD);
        wait_idle();
        chk("t6_err_stays", err_count, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
